pwm_servo_driver: RTL and testbench
===================================

PWM_SERVO_DRIVER -- requirements
Module: pwm_servo_driver

Interface
REQ-001 Parameter WIDTH_STOP, default 75000, pulse width in clk cycles for the stop command (1.5 ms at 50 MHz).
REQ-002 Parameter WIDTH_FWD, default 100000, pulse width in clk cycles for the forward command.
REQ-003 Parameter WIDTH_REV, default 50000, pulse width in clk cycles for the reverse command.
REQ-004 Parameter STALL_LIMIT, default 16, number of consecutive unchanged count samples that raises a fault.
REQ-005 Parameter RAMP_STEP, default 5000, maximum width change per period when ramping is compiled in.
REQ-006 clk  input  1  system clock, all logic on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 count  input  21  free-running timebase value; increments by 1 per clk and wraps 2^21-1 -> 0.
REQ-009 cmd  input  2  direction command: 00 stop, 01 forward, 10 reverse, 11 stop.
REQ-010 cmd_valid  input  1  cmd is valid this cycle.
REQ-011 cmd_ready  output  1  pending command slot is empty; the command is accepted when cmd_valid and cmd_ready are both 1.
REQ-012 pwm  output  1  registered servo pulse output.
REQ-013 period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.
REQ-014 fault  output  1  sticky timebase-stall indicator.

Function
REQ-015 A boundary SHALL occur in a cycle where count==0 and the registered previous sample count_q!=0; count_q resets to 21'h1FFFFF.
REQ-016 The FSM SHALL have states WAIT, HIGH, LOW, and FAULT; reset enters WAIT.
REQ-017 WAIT: pwm=0; on a boundary -> HIGH, with pwm=1 and period_start=1 in the next cycle.
REQ-018 LOW: pwm=0; on a boundary -> HIGH, with pwm=1 and period_start=1 in the next cycle.
REQ-019 HIGH: when count>=active_width -> LOW with pwm=0 next cycle; the pulse therefore lasts exactly active_width cycles.
REQ-020 The width comparison SHALL be unsigned 21-bit; active_width=0 gives a pulse of 1 cycle; a width >=2^21 is illegal and unsupported.
REQ-021 On an accepted command, pending SHALL be loaded with the width mapped from cmd, and pending_full SHALL be set; cmd_ready=!pending_full.
REQ-022 On a boundary with pending_full=1, the target SHALL be loaded from pending and pending_full SHALL clear; active_width updates only at boundaries, never mid-pulse.
REQ-023 Simultaneous accept and boundary (pending empty): the command SHALL be stored in pending and applied at the following boundary, not the current one.
REQ-024 Each cycle with count==count_q SHALL increment stall_cnt; any other cycle clears it; reaching STALL_LIMIT -> FAULT.
REQ-025 FAULT: pwm=0, period_start=0, fault=1, cmd_ready=0; the only exit is reset.
REQ-026 A command held valid while cmd_ready=0 SHALL NOT be lost; it is accepted in the first cycle cmd_ready returns to 1.

Reset
REQ-027 On reset: pwm=0, period_start=0, fault=0, cmd_ready=1, pending_full=0, stall_cnt=0, active_width=target=WIDTH_STOP, state=WAIT.
REQ-028 Reset asserted mid-pulse SHALL drive pwm=0 in the next cycle and discard any pending command.

Configuration
REQ-029 Macro PWM_SERVO_RAMP_EN: when defined, at each boundary active_width moves toward target by min(|target-active_width|, RAMP_STEP).
REQ-030 Without PWM_SERVO_RAMP_EN: at each boundary active_width equals target immediately; RAMP_STEP is unused.

Verification
REQ-031 Reset, then drive count 0..2^21-1 incrementing -> pwm high for exactly 75000 cycles starting 1 cycle after count==0, and period_start pulses once per period.
REQ-032 Accept cmd=01 mid-pulse -> the current pulse stays 75000 cycles; the next period pulse is 100000 cycles (RAMP_EN off).
REQ-033 With PWM_SERVO_RAMP_EN, stop->forward -> successive pulse widths are 80000, 85000, 90000, 95000, then 100000.
REQ-034 cmd_valid on the same cycle as the boundary with cmd=10 -> the following period is unchanged; the next period after that is 50000 cycles; cmd_ready is low for one period.
REQ-035 Hold count at 123 for 16 cycles -> fault=1 and pwm=0 from the next cycle; fault persists after count resumes, and clears only on reset.
REQ-036 Assert reset at count=40000 during HIGH -> pwm=0 next cycle; no pulse until the next count==0 boundary, which gives a 75000-cycle pulse.

Source files
------------

// File: rtl/pwm_servo_driver.sv
// Servo PWM generator locked to an external free-running 21-bit timebase.
// Defining PWM_SERVO_RAMP_EN makes width changes ramp by at most RAMP_STEP per period.
module pwm_servo_driver #(
    parameter int WIDTH_STOP  = 75000,
    parameter int WIDTH_FWD   = 100000,
    parameter int WIDTH_REV   = 50000,
    parameter int STALL_LIMIT = 16,
    parameter int RAMP_STEP   = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [20:0] count,
    input  logic [1:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        pwm,
    output logic        period_start,
    output logic        fault
);
    localparam int          SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
    localparam logic [SW-1:0] STALL_TOP = SW'(STALL_LIMIT - 1);
    localparam logic [20:0] W_STOP    = 21'(WIDTH_STOP);
    localparam logic [20:0] W_FWD     = 21'(WIDTH_FWD);
    localparam logic [20:0] W_REV     = 21'(WIDTH_REV);

    typedef enum logic [1:0] {WAIT, HIGH, LOW, FAULT} state_t;

    state_t        state, state_n;
    logic [20:0]   count_q;
    logic [SW-1:0] stall_cnt;
    logic [20:0]   pending, target, active_width;
    logic [20:0]   next_target, next_active;
    logic          pending_full;
    logic          boundary, accept, stall_hit;

    function automatic logic [20:0] map_width(input logic [1:0] c);
        case (c)
            2'b01:   return W_FWD;
            2'b10:   return W_REV;
            default: return W_STOP;
        endcase
    endfunction

    assign boundary    = (count == 21'd0) && (count_q != 21'd0);
    assign cmd_ready   = !pending_full && (state != FAULT);
    assign accept      = cmd_valid && cmd_ready;
    assign stall_hit   = (count == count_q) && (stall_cnt >= STALL_TOP);
    assign next_target = pending_full ? pending : target;

`ifdef PWM_SERVO_RAMP_EN
    localparam logic [20:0] RAMP_W = 21'(RAMP_STEP);

    // Move toward the new target, limited to one ramp step per period.
    always_comb begin
        next_active = next_target;
        if (next_target > active_width) begin
            if (next_target - active_width > RAMP_W)
                next_active = active_width + RAMP_W;
        end else if (active_width - next_target > RAMP_W) begin
            next_active = active_width - RAMP_W;
        end
    end
`else
    assign next_active = next_target;
`endif

    always_comb begin
        state_n = state;
        if (stall_hit) begin
            state_n = FAULT;
        end else begin
            case (state)
                WAIT, LOW: if (boundary) state_n = HIGH;
                HIGH:      if (count >= active_width) state_n = LOW;
                default:   state_n = FAULT;
            endcase
        end
    end

    // Outputs are registered from the next state so pwm rises the cycle after count==0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT;
            count_q      <= '1;
            stall_cnt    <= '0;
            pending      <= W_STOP;
            pending_full <= 1'b0;
            target       <= W_STOP;
            active_width <= W_STOP;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            count_q      <= count;
            pwm          <= (state_n == HIGH);
            period_start <= (state_n == HIGH) && (state != HIGH);
            fault        <= (state_n == FAULT);

            if (count != count_q)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + 1'b1;

            // A command accepted on a boundary lands in pending and waits for the next one.
            if (boundary) begin
                target       <= next_target;
                active_width <= next_active;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pending      <= map_width(cmd);
                pending_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_servo_driver.sv
// Randomized scoreboard bench for pwm_servo_driver with small pulse widths and a jumping timebase.
// Build with PWM_SERVO_RAMP_EN defined to check the ramping variant.
`timescale 1ns/1ps
module tb_pwm_servo_driver;
    localparam int          WS   = 30;
    localparam int          WF   = 50;
    localparam int          WR   = 0;
    localparam int          SL   = 16;
    localparam int          RS   = 7;
    localparam logic [20:0] CMAX = 21'h1FFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] count = '0;
    logic [1:0]  cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready, pwm, period_start, fault;

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    int          m_target, m_active, m_pending, m_stall;
    bit          m_pending_full, m_fault;
    logic [20:0] m_prev;
    bit          req;
    logic [1:0]  req_cmd = '0;
    bit          random_cmds = 0;

    bit prev_pwm = 0;
    bit in_pulse = 0;
    bit expect_low = 0;
    int pulse_len = 0;
    int exp_len;

    always #5 clk = ~clk;

    pwm_servo_driver #(
        .WIDTH_STOP(WS), .WIDTH_FWD(WF), .WIDTH_REV(WR),
        .STALL_LIMIT(SL), .RAMP_STEP(RS)
    ) dut (
        .clk(clk), .reset(reset), .count(count), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .pwm(pwm), .period_start(period_start), .fault(fault)
    );

    function automatic int width_of(input logic [1:0] c);
        if (c == 2'b01) return WF;
        if (c == 2'b10) return WR;
        return WS;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reset_model();
        m_pending_full = 0;
        m_target       = WS;
        m_active       = WS;
        m_prev         = CMAX;
        m_stall        = 0;
        m_fault        = 0;
        req            = 0;
        sb_q.delete();
    endtask

    // One clock of stimulus; the model predicts the pulse each boundary will produce.
    task automatic applyStimulus(input logic [20:0] c, input bit rst, input int force_cmd);
        bit boundary, accept_now;
`ifdef PWM_SERVO_RAMP_EN
        int diff;
`endif
        @(posedge clk);
        #1;
        checkOutput("fault", int'(fault), int'(m_fault));
        checkOutput("cmd_ready", int'(cmd_ready), (m_pending_full || m_fault) ? 0 : 1);
        if (m_fault) checkOutput("pwm_in_fault", int'(pwm), 0);
        if (!rst && !req) begin
            if (force_cmd >= 0) begin
                req     = 1;
                req_cmd = (force_cmd > 3) ? 2'($urandom_range(0, 3)) : 2'(force_cmd);
            end else if (random_cmds && $urandom_range(0, 29) == 0) begin
                req     = 1;
                req_cmd = 2'($urandom_range(0, 3));
            end
        end
        count     = c;
        reset     = rst;
        cmd_valid = rst ? 1'b0 : req;
        cmd       = req_cmd;
        if (rst) begin
            reset_model();
        end else if (!m_fault) begin
            boundary   = (c == 21'd0) && (m_prev != 21'd0);
            accept_now = req && !m_pending_full;
            m_stall    = (c == m_prev) ? m_stall + 1 : 0;
            m_prev     = c;
            if (m_stall >= SL) begin
                m_fault = 1;
            end else begin
                if (boundary) begin
                    if (m_pending_full) begin
                        m_target       = m_pending;
                        m_pending_full = 0;
                    end
`ifdef PWM_SERVO_RAMP_EN
                    diff = m_target - m_active;
                    if (diff > RS) diff = RS;
                    else if (diff < -RS) diff = -RS;
                    m_active += diff;
`else
                    m_active = m_target;
`endif
                    sb_q.push_back((m_active > 0) ? m_active : 1);
                end
                if (accept_now) begin
                    m_pending      = width_of(req_cmd);
                    m_pending_full = 1;
                    req            = 0;
                end
            end
        end
    endtask

    task automatic runPeriod(input int len, input int cmd_at, input int cmd_val);
        for (int i = 0; i <= len; i++)
            applyStimulus(21'(i), 0, (i == cmd_at) ? cmd_val : -1);
        applyStimulus(CMAX - 21'd1, 0, -1);
        applyStimulus(CMAX, 0, -1);
    endtask

    // Monitor: measures each pwm pulse and compares it against the oldest prediction.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (expect_low) begin
                checkOutput("pwm_after_reset", int'(pwm), 0);
                expect_low = 0;
            end
            checkOutput("period_start", int'(period_start), (pwm && !prev_pwm) ? 1 : 0);
            if (reset) begin
                in_pulse   = 0;
                expect_low = 1;
            end else if (pwm && !prev_pwm) begin
                checkOutput("pulse_start_count", int'(count), 1);
                checkOutput("pulse_expected", (sb_q.size() > 0) ? 1 : 0, 1);
                in_pulse  = 1;
                pulse_len = 1;
            end else if (pwm && in_pulse) begin
                pulse_len++;
            end else if (!pwm && in_pulse) begin
                in_pulse = 0;
                if (sb_q.size() > 0) begin
                    exp_len = sb_q.pop_front();
                    checkOutput("pulse_width", pulse_len, exp_len);
                end
            end
            prev_pwm = pwm;
        end
    end

    initial begin : stimulus
        reset_model();
        for (int i = 0; i < 3; i++) applyStimulus(21'(5 + i), 1, -1);
        @(negedge clk);
        checkOutput("reset_pwm", int'(pwm), 0);
        checkOutput("reset_period_start", int'(period_start), 0);
        checkOutput("reset_fault", int'(fault), 0);
        checkOutput("reset_cmd_ready", int'(cmd_ready), 1);

        for (int i = 100; i < 120; i++) applyStimulus(21'(i), 0, -1);
        applyStimulus(CMAX, 0, -1);
        runPeriod(80, -1, 0);
        runPeriod(80, 10, 1);
        repeat (3) runPeriod(80, -1, 0);

        // Reset in the middle of a pulse with a reverse command still pending.
        for (int i = 0; i <= 16; i++) applyStimulus(21'(i), 0, (i == 5) ? 2 : -1);
        applyStimulus(21'd17, 1, -1);
        for (int i = 18; i <= 80; i++) applyStimulus(21'(i), 0, -1);
        applyStimulus(CMAX - 21'd1, 0, -1);
        applyStimulus(CMAX, 0, -1);
        runPeriod(80, -1, 0);

        runPeriod(80, 0, 2);
        repeat (8) runPeriod(80, -1, 0);

        random_cmds = 1;
        repeat (30) runPeriod(int'($urandom_range(60, 150)), int'($urandom_range(0, 200)) - 50, 4);
        random_cmds = 0;

        // Stalled timebase: hold count at 123 until the fault latches, then resume.
        for (int i = 0; i <= 123; i++) applyStimulus(21'(i), 0, -1);
        repeat (SL) applyStimulus(21'd123, 0, -1);
        for (int i = 124; i <= 140; i++) applyStimulus(21'(i), 0, -1);
        applyStimulus(CMAX, 0, -1);
        for (int i = 0; i <= 40; i++) applyStimulus(21'(i), 0, (i == 3) ? 1 : -1);
        applyStimulus(21'd41, 1, -1);
        applyStimulus(21'd42, 1, -1);
        applyStimulus(21'd43, 0, -1);
        applyStimulus(CMAX, 0, -1);
        runPeriod(80, -1, 0);
        runPeriod(80, -1, 0);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
